// File: rtl/iram_arbiter.sv
// iram_arbiter: shares the single instruction-RAM port between the CPU fetch
// unit (read-only) and the program loader (write-only).
//
// Every output is driven straight from a register. A request sampled in IDLE
// produces the grant, the RAM strobe, the address and the write data together
// in the following (ACCESS) cycle. Read data returns one cycle later (RWAIT)
// and is presented to the fetch unit on the cycle after that.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | arbitrate between eligible requesters, launch the winner
//   ACCESS  | RAM strobe active, winner's gnt (and err) pulsing
//   RWAIT   | RAM read data valid on ram_rdata, captured into fetch_data
//
// fetch_valid pulses in the IDLE cycle that follows RWAIT. That IDLE cycle may
// already be sampling the next request.

module iram_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_mode,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_err,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_gnt,
   output logic              load_err,
   output logic [7:0]        load_count,
   output logic              ram_write_en,
   output logic              ram_read_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RWAIT  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_LOAD  = 1'b1
   } owner_e;

   // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   state_e            state_q,       state_d;
   owner_e            rr_last_q,     rr_last_d;
   logic              fetch_gnt_q,   fetch_gnt_d;
   logic              fetch_err_q,   fetch_err_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic [DATA_W-1:0] fetch_data_q,  fetch_data_d;
   logic              load_gnt_q,    load_gnt_d;
   logic              load_err_q,    load_err_d;
   logic [7:0]        load_count_q,  load_count_d;
   logic              ram_we_q,      ram_we_d;
   logic              ram_re_q,      ram_re_d;
   logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q,   ram_wdata_d;

   logic fetch_elig;
   logic load_elig;
   logic pick_fetch;
   logic pick_load;
   logic fetch_ok;
   logic load_ok;

   // Eligibility, round-robin tie-break and address range checks.
   always_comb begin
      fetch_elig = fetch_req & ~load_mode;
      load_elig  = load_req;
      pick_fetch = fetch_elig & (~load_elig | (rr_last_q == OWN_LOAD));
      pick_load  = load_elig & ~pick_fetch;
      fetch_ok   = ({1'b0, fetch_addr} < DEPTH_X);
      load_ok    = ({1'b0, load_addr}  < DEPTH_X);
   end

   // Next-state and registered-output logic for the access sequencer.
   always_comb begin
      state_d       = state_q;
      rr_last_d     = rr_last_q;
      fetch_gnt_d   = 1'b0;
      fetch_err_d   = 1'b0;
      fetch_valid_d = 1'b0;
      fetch_data_d  = fetch_data_q;
      load_gnt_d    = 1'b0;
      load_err_d    = 1'b0;
      load_count_d  = load_count_q;
      ram_we_d      = 1'b0;
      ram_re_d      = 1'b0;
      ram_addr_d    = ram_addr_q;
      ram_wdata_d   = ram_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_fetch) begin
               state_d     = ST_ACCESS;
               rr_last_d   = OWN_FETCH;
               fetch_gnt_d = 1'b1;
               fetch_err_d = ~fetch_ok;
               ram_re_d    = fetch_ok;
               ram_addr_d  = fetch_addr;
               ram_wdata_d = '0;
            end else if (pick_load) begin
               state_d     = ST_ACCESS;
               rr_last_d   = OWN_LOAD;
               load_gnt_d  = 1'b1;
               load_err_d  = ~load_ok;
               ram_we_d    = load_ok;
               ram_addr_d  = load_addr;
               ram_wdata_d = load_data;
               if (load_ok && (load_count_q != 8'hFF)) begin
                  load_count_d = load_count_q + 8'd1;
               end
            end
         end

         // Only a legal fetch has its read strobe up here, so that alone
         // decides whether a read result has to be collected.
         ST_ACCESS: begin
            state_d = ram_re_q ? ST_RWAIT : ST_IDLE;
         end

         ST_RWAIT: begin
            fetch_data_d  = ram_rdata;
            fetch_valid_d = 1'b1;
            state_d       = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any read that is in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         rr_last_q     <= OWN_LOAD;
         fetch_gnt_q   <= 1'b0;
         fetch_err_q   <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_data_q  <= '0;
         load_gnt_q    <= 1'b0;
         load_err_q    <= 1'b0;
         load_count_q  <= '0;
         ram_we_q      <= 1'b0;
         ram_re_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         rr_last_q     <= rr_last_d;
         fetch_gnt_q   <= fetch_gnt_d;
         fetch_err_q   <= fetch_err_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_data_q  <= fetch_data_d;
         load_gnt_q    <= load_gnt_d;
         load_err_q    <= load_err_d;
         load_count_q  <= load_count_d;
         ram_we_q      <= ram_we_d;
         ram_re_q      <= ram_re_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
      end
   end

   assign fetch_gnt    = fetch_gnt_q;
   assign fetch_err    = fetch_err_q;
   assign fetch_valid  = fetch_valid_q;
   assign fetch_data   = fetch_data_q;
   assign load_gnt     = load_gnt_q;
   assign load_err     = load_err_q;
   assign load_count   = load_count_q;
   assign ram_write_en = ram_we_q;
   assign ram_read_en  = ram_re_q;
   assign ram_addr     = ram_addr_q;
   assign ram_wdata    = ram_wdata_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iram_arbiter.sv
// tb_iram_arbiter: directed and random requests against a transaction-level
// model of the arbiter (pending requests, last winner, shadow memory, write
// count) with a behavioural 32-word RAM attached to the RAM pins.

module tb_iram_arbiter;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load_mode;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_data;
   logic              fetch_err;
   logic              load_req;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              load_gnt;
   logic              load_err;
   logic [7:0]        load_count;
   logic              ram_write_en;
   logic              ram_read_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata = '0;
   logic              busy;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   iram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_mode    (load_mode),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_gnt    (fetch_gnt),
      .fetch_valid  (fetch_valid),
      .fetch_data   (fetch_data),
      .fetch_err    (fetch_err),
      .load_req     (load_req),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_gnt     (load_gnt),
      .load_err     (load_err),
      .load_count   (load_count),
      .ram_write_en (ram_write_en),
      .ram_read_en  (ram_read_en),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(input int i);
      return 16'(i * 512 + 1);
   endfunction

   // Behavioural single-port RAM: preloaded on the first reset, read data one
   // cycle after read_en.
   logic [15:0] mem [0:31];
   logic        mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!rst_n && !mem_loaded) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
         mem_loaded <= 1'b1;
      end else begin
         if (ram_write_en && (ram_addr < 9'd32)) mem[ram_addr[4:0]] <= ram_wdata;
         if (ram_read_en) ram_rdata <= (ram_addr < 9'd32) ? mem[ram_addr[4:0]] : 16'hDEAD;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobes are exclusive and only appear while the sequencer is busy.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("strobe_overlap", 32'(ram_write_en & ram_read_en), 32'd0);
         chk("strobe_outside_access", 32'((ram_write_en | ram_read_en) & ~busy), 32'd0);
      end
   end

   // ---------------- reference model ----------------
   bit          lm;
   bit          f_pend, l_pend;
   logic [8:0]  f_a, l_a;
   logic [15:0] l_d;
   bit          rr_last_load;
   int          exp_cnt;
   logic [15:0] exp_fdata;
   logic [15:0] exp_mem [0:31];

   task automatic apply();
      load_mode  = lm;
      fetch_req  = f_pend;
      fetch_addr = f_a;
      load_req   = l_pend;
      load_addr  = l_a;
      load_data  = l_d;
   endtask

   function automatic logic [8:0] rand_addr();
      if ($urandom_range(0, 5) == 0) return 9'($urandom_range(32, 511));
      return 9'($urandom_range(0, 31));
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_fetch_gnt"},   32'(fetch_gnt),    32'd0);
      chk({tag, "_fetch_valid"}, 32'(fetch_valid),  32'd0);
      chk({tag, "_fetch_data"},  32'(fetch_data),   32'd0);
      chk({tag, "_fetch_err"},   32'(fetch_err),    32'd0);
      chk({tag, "_load_gnt"},    32'(load_gnt),     32'd0);
      chk({tag, "_load_err"},    32'(load_err),     32'd0);
      chk({tag, "_load_count"},  32'(load_count),   32'd0);
      chk({tag, "_write_en"},    32'(ram_write_en), 32'd0);
      chk({tag, "_read_en"},     32'(ram_read_en),  32'd0);
      chk({tag, "_ram_addr"},    32'(ram_addr),     32'd0);
      chk({tag, "_ram_wdata"},   32'(ram_wdata),    32'd0);
      chk({tag, "_busy"},        32'(busy),         32'd0);
   endtask

   // Called in an IDLE cycle. Lets the model pick a winner, follows that one
   // transaction to completion and returns with the DUT in IDLE again.
   // obs_who reports what the DUT granted: 0 none, 1 fetch, 2 load.
   task automatic serve_one(input bit rearm, output int obs_who, output bit served);
      bit          fe, le, win_f, ok;
      logic [8:0]  addr;
      logic [15:0] data;
      fe = f_pend && !lm;
      le = l_pend;
      obs_who = 0;
      served  = 1'b0;
      if (!fe && !le) begin
         @(posedge clk); #1;
         chk("idle_fetch_gnt", 32'(fetch_gnt), 32'd0);
         chk("idle_load_gnt",  32'(load_gnt),  32'd0);
         chk("idle_busy",      32'(busy),      32'd0);
         return;
      end
      served = 1'b1;
      win_f = fe && (!le || rr_last_load);
      rr_last_load = !win_f;
      addr = win_f ? f_a : l_a;
      data = win_f ? 16'd0 : l_d;
      ok   = (addr < 9'(DEPTH));

      @(posedge clk); #1;
      obs_who = fetch_gnt ? 1 : (load_gnt ? 2 : 0);
      chk("fetch_gnt",    32'(fetch_gnt),    32'(win_f));
      chk("load_gnt",     32'(load_gnt),     32'(!win_f));
      chk("fetch_err",    32'(fetch_err),    32'(win_f && !ok));
      chk("load_err",     32'(load_err),     32'(!win_f && !ok));
      chk("ram_read_en",  32'(ram_read_en),  32'(win_f && ok));
      chk("ram_write_en", 32'(ram_write_en), 32'(!win_f && ok));
      chk("ram_addr",     32'(ram_addr),     32'(addr));
      chk("ram_wdata",    32'(ram_wdata),    32'(data));
      chk("busy_access",  32'(busy),         32'd1);
      chk("valid_access", 32'(fetch_valid),  32'd0);
      if (!win_f && ok) begin
         exp_mem[addr[4:0]] = data;
         if (exp_cnt < 255) exp_cnt++;
      end
      chk("load_count", 32'(load_count), 32'(exp_cnt));

      if (win_f) begin
         if (rearm) f_a = 9'($urandom_range(0, 31)); else f_pend = 1'b0;
      end else begin
         if (rearm) begin
            l_a = 9'($urandom_range(0, 31));
            l_d = 16'($urandom);
         end else l_pend = 1'b0;
      end
      apply();

      if (win_f && ok) begin
         @(posedge clk); #1;
         chk("busy_rwait",      32'(busy),        32'd1);
         chk("read_en_rwait",   32'(ram_read_en), 32'd0);
         chk("fetch_gnt_rwait", 32'(fetch_gnt),   32'd0);
         chk("valid_rwait",     32'(fetch_valid), 32'd0);
         exp_fdata = exp_mem[addr[4:0]];
         @(posedge clk); #1;
         chk("fetch_valid", 32'(fetch_valid), 32'd1);
         chk("fetch_data",  32'(fetch_data),  32'(exp_fdata));
         chk("busy_done",   32'(busy),        32'd0);
      end else begin
         @(posedge clk); #1;
         chk("busy_done",      32'(busy),        32'd0);
         chk("fetch_gnt_done", 32'(fetch_gnt),   32'd0);
         chk("load_gnt_done",  32'(load_gnt),    32'd0);
         chk("no_valid",       32'(fetch_valid), 32'd0);
         chk("data_hold",      32'(fetch_data),  32'(exp_fdata));
      end
   endtask

   task automatic serve_all();
      int  who;
      bit  served;
      for (int k = 0; k < 3; k++) begin
         serve_one(1'b0, who, served);
         if (!served) break;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int who;
      bit served;

      rst_n = 1'b0;
      lm = 1'b0; f_pend = 1'b0; l_pend = 1'b0;
      f_a = '0; l_a = '0; l_d = '0;
      rr_last_load = 1'b1; exp_cnt = 0; exp_fdata = '0;
      for (int i = 0; i < 32; i++) exp_mem[i] = init_word(i);
      apply();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Fetch of word 2 straight after reset.
      f_pend = 1'b1; f_a = 9'd2; apply();
      serve_one(1'b0, who, served);
      chk("tp1_who",  32'(who),        32'd1);
      chk("tp1_data", 32'(fetch_data), 32'd1025);

      // Load in load_mode, then fetch it back.
      lm = 1'b1; l_pend = 1'b1; l_a = 9'd7; l_d = 16'hBEEF;
      f_pend = 1'b1; f_a = 9'd5; apply();
      serve_one(1'b0, who, served);
      chk("tp2_who",   32'(who),        32'd2);
      chk("tp2_count", 32'(load_count), 32'd1);
      f_pend = 1'b0; apply();
      serve_one(1'b0, who, served);
      chk("tp2_blocked", 32'(served), 32'd0);
      lm = 1'b0; f_pend = 1'b1; f_a = 9'd7; apply();
      serve_one(1'b0, who, served);
      chk("tp2_data", 32'(fetch_data), 32'hBEEF);

      // Out-of-range load and fetch requested together.
      l_pend = 1'b1; l_a = 9'd32; l_d = 16'h1234;
      f_pend = 1'b1; f_a = 9'd300; apply();
      serve_all();
      chk("tp4_count", 32'(load_count), 32'd1);
      chk("tp4_data",  32'(fetch_data), 32'hBEEF);

      // Reset while an addr-3 fetch sits in RWAIT.
      f_pend = 1'b1; f_a = 9'd3; apply();
      @(posedge clk); #1;
      chk("rst_mid_gnt", 32'(fetch_gnt), 32'd1);
      f_pend = 1'b0; apply();
      @(posedge clk); #1;
      chk("rst_mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_all_zero("rst_mid");
      rst_n = 1'b1;
      rr_last_load = 1'b1; exp_cnt = 0; exp_fdata = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("rst_mid_no_valid", 32'(fetch_valid), 32'd0);
      end

      // Both requesters held continuously: strict alternation from fetch.
      f_pend = 1'b1; f_a = 9'd9; l_pend = 1'b1; l_a = 9'd10; l_d = 16'h5A5A; apply();
      for (int k = 0; k < 6; k++) begin
         serve_one(1'b1, who, served);
         chk("alternate", 32'(who), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      f_pend = 1'b0; l_pend = 1'b0; apply();
      serve_one(1'b0, who, served);

      // Random traffic, including blocked and abandoned fetches.
      for (int it = 0; it < 80; it++) begin
         lm     = ($urandom_range(0, 3) == 0);
         f_pend = 1'($urandom_range(0, 1));
         f_a    = rand_addr();
         l_pend = 1'($urandom_range(0, 1));
         l_a    = rand_addr();
         l_d    = 16'($urandom);
         apply();
         serve_all();
         if (f_pend) begin
            f_pend = 1'b0; apply();
         end
      end

      // Saturation of the write counter.
      lm = 1'b1; f_pend = 1'b0;
      for (int k = 0; k < 260; k++) begin
         l_pend = 1'b1; l_a = 9'($urandom_range(0, 31)); l_d = 16'($urandom);
         apply();
         serve_one(1'b0, who, served);
      end
      chk("count_saturated", 32'(load_count), 32'd255);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iram_arbiter.md
Name: iram_arbiter

Overview:
- Owns the single port of the instruction RAM and shares it between two requesters: the CPU fetch unit (read-only) and the program loader (write-only).
- Serialises accesses through a small FSM, drives the RAM's write_en/read_en/addr/Data_in pins, and returns registered read data to the fetch unit.
- A load_mode input locks the CPU out while a program is being loaded.
- Rejects out-of-range addresses so that the 32-entry array is never indexed past its depth.

Parameters:
- ADDR_W, 9, width of all address buses (matches the RAM addr pin)
- DATA_W, 16, instruction word width
- DEPTH, 32, number of implemented RAM words; addresses >= DEPTH are illegal

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- load_mode  in  1  1 = loader owns RAM, fetch requests are held off
- fetch_req  in  1  fetch read request; held until fetch_gnt
- fetch_addr  in  ADDR_W  fetch address
- fetch_gnt  out  1  one-cycle pulse: fetch request accepted
- fetch_valid  out  1  one-cycle pulse: fetch_data valid
- fetch_data  out  DATA_W  registered read data; holds until the next valid
- fetch_err  out  1  one-cycle pulse with fetch_gnt: address out of range
- load_req  in  1  loader write request; held until load_gnt
- load_addr  in  ADDR_W  write address
- load_data  in  DATA_W  write data
- load_gnt  out  1  one-cycle pulse: write performed (or rejected)
- load_err  out  1  one-cycle pulse with load_gnt: address out of range
- load_count  out  8  saturating count of successful writes since reset
- ram_write_en  out  1  to RAM write_en
- ram_read_en  out  1  to RAM read_en
- ram_addr  out  ADDR_W  to RAM addr
- ram_wdata  out  DATA_W  to RAM Data_in
- ram_rdata  in  DATA_W  from RAM Data_out (valid the cycle after read_en)
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous, active-low.
- Reset values: all outputs 0. FSM goes to IDLE and rr_last (last winner) = LOAD, so fetch wins the first tie. Any in-flight read is dropped and no fetch_valid is issued, including when reset occurs mid-operation.
- States:
  - IDLE: arbitrates.
  - ACCESS: RAM strobes are active.
  - RWAIT: RAM output is captured.
- Eligibility, sampled in IDLE at cycle N:
  - fetch is eligible if fetch_req=1 and load_mode=0.
  - load is eligible if load_req=1.
  - If both are eligible, the one that is not rr_last wins, and rr_last is updated.
  - If neither is eligible, stay in IDLE.
- ACCESS (cycle N+1), all outputs registered:
  - ram_addr = winner address. ram_wdata = load_data for a load winner, 0 for a fetch winner.
  - The winner's gnt pulses.
  - Legal load: ram_write_en=1, then go to IDLE. load_count += 1, saturating at 255.
  - Legal fetch: ram_read_en=1, then go to RWAIT.
  - Illegal address (>= DEPTH): no strobe, err pulses with gnt, go to IDLE. No fetch_valid is issued and load_count is unchanged.
- RWAIT (cycle N+2): capture ram_rdata into fetch_data, then go to IDLE.
- fetch_valid: pulses high in cycle N+3 while the FSM is back in IDLE, which may already be sampling the next request.
- Latency and throughput:
  - Fetch: 3 cycles from sampled request to valid; one read per 3 cycles.
  - Load: 1 cycle to gnt; one write per 2 cycles.
- Strobes: ram_write_en and ram_read_en are never both 1 and are each high only in ACCESS.
- load_mode changes take effect at the next IDLE sample; an accepted fetch always completes.
- Requesters must keep req, address and data stable until their gnt. If req drops before grant, the request is abandoned with no side effect.
- Write followed by fetch of the same address returns the new data, because the accesses are serialised.

Test Plan:
- Reset, then fetch_req with addr 2, RAM word[2]=1025: gnt at N+1, fetch_valid at N+3 with fetch_data=1025, busy high for N+1..N+2.
- load_mode=1; load addr 7 with data 0xBEEF; then load_mode=0 and fetch addr 7: load_gnt and load_count=1, then fetch_data=0xBEEF.
- fetch_req and load_req both held continuously (load_mode=0): grants alternate fetch, load, fetch, load, starting with fetch; strobes never overlap.
- load addr 32 and fetch addr 300: load_gnt+load_err and fetch_gnt+fetch_err pulse; no RAM strobe; no fetch_valid; load_count unchanged.
- rst_n=0 in RWAIT of an addr-3 fetch: no fetch_valid ever appears; all outputs are 0 the cycle after reset; the next tie-break goes to fetch.
- 260 legal writes: load_count saturates at 255.
